// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg -- shared types and sizes for the systolic-array writeback path.
// Holds the vector register type, the default writeback buffer depth and the
// buffered writeback entry layout.
package sys_arr_pkg;

  localparam int VREG_W   = 512;
  localparam int WB_DEPTH = 4;

  typedef logic [VREG_W-1:0] vreg_t;

  // One buffered writeback: the partial-sum vector and its destination register.
  typedef struct packed {
    vreg_t      psum;
    logic [7:0] vdst;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo -- generic in-order FIFO with wrap-bit pointers.
// Storage, pointers and occupancy only; handshake policy lives in the parent.
// Pointers carry one extra wrap bit: equal pointers mean empty, equal index
// with differing wrap bits means full. Occupancy is the pointer difference.
import sys_arr_pkg::*;

module wb_fifo #(
  parameter int  DEPTH   = WB_DEPTH,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  logic do_push;
  logic do_pop;

  // Occupancy flags and guarded push/pop derived from registered pointers only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    empty   = 1'b0;
    full    = 1'b0;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    do_push = push && !full && !clear;
    do_pop  = pop && !empty && !clear;
  end

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage written at the tail index.
  // NOTE: the storage array has no reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sa_wb_buffer.sv
// sa_wb_buffer -- writeback buffer between the GSAU and the vector register file.
// Accepts psum/wbdst offers into an in-order FIFO, presents the head entry as a
// register-file write, and pulses done_valid/done_vdst one cycle after each
// committed write. flush discards everything synchronously.
// Optional feature: define WB_BYPASS_EN to let an offer into an empty buffer
// drive the register-file write in the same cycle.
import sys_arr_pkg::*;

module sa_wb_buffer #(
  parameter int DEPTH  = WB_DEPTH,
  parameter int VDST_W = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  vreg_t                  psum,
  input  logic [VDST_W-1:0]      wbdst,
  input  logic                   wb_valid,
  output logic                   output_ready,
  output logic                   rf_wen,
  output logic [VDST_W-1:0]      rf_vdst,
  output vreg_t                  rf_wdata,
  input  logic                   rf_ack,
  output logic                   done_valid,
  output logic [VDST_W-1:0]      done_vdst,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  // Same layout as wb_entry_t, sized by VDST_W (identical at the default width).
  typedef struct packed {
    vreg_t             psum;
    logic [VDST_W-1:0] vdst;
  } entry_t;

  entry_t in_entry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_push;
  logic   fifo_pop;
  logic   bypass;
  logic   commit;

  assign in_entry = '{psum: psum, vdst: wbdst};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_entry),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Handshake, bypass selection and commit detection.
  always_comb begin
    bypass       = 1'b0;
`ifdef WB_BYPASS_EN
    bypass       = fifo_empty && wb_valid && !flush;
`endif
    output_ready = !fifo_full && !flush;
    rf_wen       = !fifo_empty || bypass;
    rf_vdst      = bypass ? wbdst : head.vdst;
    rf_wdata     = bypass ? psum  : head.psum;
    fifo_pop     = !fifo_empty && rf_ack && !flush;
    // A bypassed offer that is acknowledged is consumed without being stored.
    fifo_push    = wb_valid && output_ready && !(bypass && rf_ack);
    commit       = fifo_pop || (bypass && rf_ack);
  end

  // Registered completion pulse for the scoreboard.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      done_valid <= 1'b0;
      done_vdst  <= '0;
    end else begin
      done_valid <= commit;
      if (commit) done_vdst <= rf_vdst;
    end
  end

endmodule

// File: tb/tb_sa_wb_buffer.sv
// tb_sa_wb_buffer -- directed self-checking bench for sa_wb_buffer (DEPTH=4).
// Expectations assume the build configuration of the DUT: WB_BYPASS_EN
// selects the same-cycle bypass expectations.
`timescale 1ns/1ps
import sys_arr_pkg::*;

module tb_sa_wb_buffer;

  logic        CLK;
  logic        nRST;
  vreg_t       psum;
  logic [7:0]  wbdst;
  logic        wb_valid;
  logic        output_ready;
  logic        rf_wen;
  logic [7:0]  rf_vdst;
  vreg_t       rf_wdata;
  logic        rf_ack;
  logic        done_valid;
  logic [7:0]  done_vdst;
  logic        flush;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  sa_wb_buffer #(.DEPTH(4), .VDST_W(8)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .psum         (psum),
    .wbdst        (wbdst),
    .wb_valid     (wb_valid),
    .output_ready (output_ready),
    .rf_wen       (rf_wen),
    .rf_vdst      (rf_vdst),
    .rf_wdata     (rf_wdata),
    .rf_ack       (rf_ack),
    .done_valid   (done_valid),
    .done_vdst    (done_vdst),
    .flush        (flush),
    .count        (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic vreg_t pat(input int k);
    logic [31:0] w;
    w = 32'(k) | 32'hC0DE_0000;
    return {16{w}};
  endfunction

  task automatic offer(input int k);
    wb_valid = 1'b1;
    wbdst    = 8'(k);
    psum     = pat(k);
  endtask

  initial begin
    nRST = 1'b0; psum = '0; wbdst = '0; wb_valid = 1'b0; rf_ack = 1'b0; flush = 1'b0;

    // Reset state
    #12;
    check("rst_count", count, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_ready", output_ready, 1);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_vdst", done_vdst, 0);
    nRST = 1'b1;
    step();

`ifndef WB_BYPASS_EN
    // Single write with rf_ack held high: one-cycle latency, then done pulse.
    wb_valid = 1'b1; wbdst = 8'd3; psum = {64{8'hA5}}; rf_ack = 1'b1;
    #1;
    check("lat_ready", output_ready, 1);
    check("lat_no_comb_wen", rf_wen, 0);
    step();
    wb_valid = 1'b0;
    #1;
    check("lat_rf_wen", rf_wen, 1);
    check("lat_rf_vdst", rf_vdst, 3);
    check("lat_rf_wdata", rf_wdata, {64{8'hA5}});
    check("lat_count1", count, 1);
    check("lat_no_done_yet", done_valid, 0);
    step();
    check("lat_done_valid", done_valid, 1);
    check("lat_done_vdst", done_vdst, 3);
    check("lat_count0", count, 0);
    check("lat_rf_wen_off", rf_wen, 0);
    step();
    check("lat_done_clear", done_valid, 0);
`else
    // Bypass: empty buffer, offer and ack together commit in the same cycle.
    wb_valid = 1'b1; wbdst = 8'd7; psum = {64{8'hA5}}; rf_ack = 1'b1;
    #1;
    check("byp_rf_wen", rf_wen, 1);
    check("byp_rf_vdst", rf_vdst, 7);
    check("byp_rf_wdata", rf_wdata, {64{8'hA5}});
    step();
    wb_valid = 1'b0;
    #1;
    check("byp_count0", count, 0);
    check("byp_done_valid", done_valid, 1);
    check("byp_done_vdst", done_vdst, 7);
    step();
    check("byp_done_clear", done_valid, 0);
`endif

    // Fill to DEPTH with rf_ack low, then hold a fifth offer for 3 cycles.
    rf_ack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      offer(k);
      step();
    end
    offer(5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("full_count", count, 4);
      check("full_ready", output_ready, 0);
      check("full_head", rf_vdst, 1);
      step();
    end
    wb_valid = 1'b0;
    rf_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("drain_vdst", rf_vdst, k);
      check("drain_wdata", rf_wdata, pat(k));
      step();
      check("drain_done_vdst", done_vdst, k);
      check("drain_done_valid", done_valid, 1);
    end
    check("drain_count0", count, 0);
    check("drain_wen_off", rf_wen, 0);

    // Refill across the pointer wrap, then pop at full with an offer waiting.
    rf_ack = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      offer(k);
      step();
    end
    check("wrap_full_count", count, 4);
    offer(15); rf_ack = 1'b1;
    #1;
    check("wrap_full_ready", output_ready, 0);
    step();
    rf_ack = 1'b0;
    #1;
    check("wrap_popped_done", done_vdst, 11);
    check("wrap_ready_again", output_ready, 1);
    step();
    wb_valid = 1'b0;
    #1;
    check("wrap_count4", count, 4);
    check("wrap_head12", rf_vdst, 12);

    // Simultaneous push and pop at count=3 keeps count and preserves the entry.
    rf_ack = 1'b1;
    step();
    check("sim_count3", count, 3);
    offer(16);
    step();
    wb_valid = 1'b0;
    #1;
    check("sim_count_kept", count, 3);
    check("sim_done13", done_vdst, 13);
    for (int k = 14; k <= 16; k++) begin
      check("sim_drain_vdst", rf_vdst, k);
      check("sim_drain_wdata", rf_wdata, pat(k));
      step();
    end
    check("sim_count0", count, 0);
    check("sim_last_done", done_vdst, 16);

    // Flush three entries; ack and a new offer in the flush cycle are ignored.
    rf_ack = 1'b0;
    for (int k = 21; k <= 23; k++) begin
      offer(k);
      step();
    end
    check("fl_count3", count, 3);
    offer(24); rf_ack = 1'b1; flush = 1'b1;
    #1;
    check("fl_ready_low", output_ready, 0);
    step();
    flush = 1'b0; wb_valid = 1'b0; rf_ack = 1'b0;
    #1;
    check("fl_count0", count, 0);
    check("fl_wen_off", rf_wen, 0);
    check("fl_no_done", done_valid, 0);
    step();
    check("fl_no_done_later", done_valid, 0);
    offer(25);
    step();
    wb_valid = 1'b0; rf_ack = 1'b1;
    #1;
    check("fl_after_vdst", rf_vdst, 25);
    check("fl_after_wdata", rf_wdata, pat(25));
    step();
    check("fl_after_done", done_vdst, 25);
    check("fl_after_done_valid", done_valid, 1);

    // Asynchronous reset with two entries pending.
    rf_ack = 1'b0;
    offer(31); step();
    offer(32); step();
    wb_valid = 1'b0;
    check("ar_count2", count, 2);
    check("ar_wen_on", rf_wen, 1);
    #2;
    nRST = 1'b0;
    #1;
    check("ar_wen_off", rf_wen, 0);
    check("ar_ready", output_ready, 1);
    check("ar_count0", count, 0);
    check("ar_done_off", done_valid, 0);
    #2;
    nRST = 1'b1;
    rf_ack = 1'b1;
    step();
    check("ar_no_done", done_valid, 0);
    check("ar_still_empty", rf_wen, 0);
    step();
    check("ar_no_done_later", done_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sa_wb_buffer.md
SA_WB_BUFFER -- requirements
Module: sa_wb_buffer

Interface
REQ-001 Parameter: DEPTH, default 4 (sys_arr_pkg::WB_DEPTH), number of buffered writeback entries; power of two, at least 2.
REQ-002 Parameter: VDST_W, default 8, destination register index width.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: nRST  in  1  reset, asynchronous, active-low.
REQ-005 Port: psum  in  512 (vreg_t)  partial-sum vector from GSAU.
REQ-006 Port: wbdst  in  VDST_W  destination vector register for psum.
REQ-007 Port: wb_valid  in  1  GSAU offers psum/wbdst.
REQ-008 Port: output_ready  out  1  buffer accepts offer this cycle.
REQ-009 Port: rf_wen  out  1  write request to vector register file.
REQ-010 Port: rf_vdst  out  VDST_W  write destination index.
REQ-011 Port: rf_wdata  out  512  write data.
REQ-012 Port: rf_ack  in  1  register file accepts the write this cycle.
REQ-013 Port: done_valid  out  1  one-cycle pulse: a write committed.
REQ-014 Port: done_vdst  out  VDST_W  index of the committed write, for the scoreboard.
REQ-015 Port: flush  in  1  synchronous discard of all buffered entries.
REQ-016 Port: count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 push = wb_valid && output_ready; pop = rf_wen && rf_ack; storage is an in-order FIFO of {psum, wbdst}.
REQ-018 output_ready = (count != DEPTH) && !flush; it is combinational from registered state and flush only, with no dependency on wb_valid.
REQ-019 rf_wen = (count != 0); rf_vdst and rf_wdata come from the head entry and stay stable while rf_wen=1 and rf_ack=0.
REQ-020 Latency, no bypass: a push at edge N makes rf_wen=1 in the cycle after edge N when the buffer was empty.
REQ-021 Simultaneous push and pop: count is unchanged; head advances; tail writes; the entry is preserved even at count=DEPTH-1.
REQ-022 Full condition (count=DEPTH): output_ready=0; wb_valid is ignored; GSAU holds its data, and the buffer does not latch it.
REQ-023 Empty condition: rf_ack is ignored; no pointer or count change occurs.
REQ-024 Pointers carry one extra wrap bit; full means equal index with differing wrap bits; wrap-around at DEPTH-1 to 0 is seamless.
REQ-025 On pop at edge N: done_valid=1 and done_vdst=popped index for exactly the cycle after edge N; otherwise done_valid=0.
REQ-026 flush=1 at edge N sets pointers and count to 0 and blocks push and pop; done_valid is 0 after edge N; flush has priority over push, pop and bypass.

Reset
REQ-027 nRST low asynchronously forces pointers=0, count=0, done_valid=0, done_vdst=0; rf_wen is therefore 0 and output_ready is 1.
REQ-028 Reset mid-operation drops all entries without issuing done_valid; storage contents need no reset.

Configuration
REQ-029 Macro WB_BYPASS_EN defined: when count=0, wb_valid=1 and flush=0, rf_wen=1 in the same cycle with rf_vdst=wbdst and rf_wdata=psum.
REQ-030 In bypass, if rf_ack=1 the entry is not stored (count stays 0) and done_valid pulses next cycle; if rf_ack=0 the entry is pushed normally.
REQ-031 Macro WB_BYPASS_EN undefined: no combinational path exists from wb_valid, psum or wbdst to any output; minimum latency is 1 cycle.

Structure
REQ-032 sys_arr_pkg holds WB_DEPTH and the struct wb_entry_t {vreg_t psum; logic [7:0] vdst}.
REQ-033 A generic sub-module wb_fifo holds storage, pointers and count; sa_wb_buffer adds the handshake, bypass, flush and done logic.

Verification
REQ-034 Push 0xA5.. to vdst 3 while rf_ack is held 1 -> rf_wen is seen 1 cycle later, then done_valid with done_vdst=3 the next cycle; count returns to 0.
REQ-035 With rf_ack=0, push vdst 1,2,3,4 (DEPTH=4) -> count=4 and output_ready=0; a 5th offer held 3 cycles is not accepted; releasing rf_ack drains 1,2,3,4 in order.
REQ-036 At count=4, assert wb_valid and rf_ack together -> head pops, then the waiting offer is accepted next cycle; count stays 4 across the wrap.
REQ-037 Three entries buffered, pulse flush -> count=0, rf_wen=0, and no done_valid pulses occur; the next push works normally.
REQ-038 Drop nRST while 2 entries are buffered and rf_wen=1 -> rf_wen=0 immediately and output_ready=1; no done_valid pulse occurs after release.
REQ-039 With WB_BYPASS_EN, empty buffer, wb_valid and rf_ack both 1 with vdst 7 -> rf_wen=1 the same cycle, count stays 0, done_vdst=7 next cycle.
